// File: rtl/mac_sequencer.sv
// mac_sequencer: sum of N_PAIRS 3x3 unsigned products through one shared multiplier, start/busy/done handshake
module mac_sequencer #(
  parameter int N_PAIRS = 2,
  parameter int ACC_W   = 7,
  parameter int IDX_W   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [6*N_PAIRS-1:0]   operands,
  output logic                   busy,
  output logic                   done,
  output logic [ACC_W-1:0]       result,
  output logic                   ovf
);
  localparam int SUM_W = ACC_W + 1;
  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;
  state_t               state_q;
  logic [6*N_PAIRS-1:0] opl_q;
  logic [5:0]           prod_q, prod_d;
  logic [ACC_W-1:0]     acc_q, result_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 ovf_acc_q, ovf_q, busy_q, done_q;
  logic [2:0]           x_d, y_d;
  logic [SUM_W-1:0]     sum_d;
  logic                 last_d;
  // select the current pair from the latched operands, multiply it and form the next accumulation
  always_comb begin
    x_d    = opl_q[6*idx_q+3 +: 3];
    y_d    = opl_q[6*idx_q +: 3];
    prod_d = {3'b000, x_d} * {3'b000, y_d};
    sum_d  = {1'b0, acc_q} + SUM_W'(prod_q);
    last_d = idx_q == IDX_W'(N_PAIRS - 1);
  end
  // sequencer: IDLE -> (MUL -> ACC) x N_PAIRS -> DONE -> IDLE, all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opl_q     <= '0;
      prod_q    <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      ovf_acc_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          opl_q     <= operands;
          acc_q     <= '0;
          idx_q     <= '0;
          ovf_acc_q <= 1'b0;
          busy_q    <= 1'b1;
          state_q   <= MUL;
        end
        MUL: begin
          prod_q  <= prod_d;
          state_q <= ACC;
        end
        ACC: begin
          acc_q     <= sum_d[ACC_W-1:0];
          ovf_acc_q <= ovf_acc_q | sum_d[ACC_W];
          if (last_d) begin
            result_q <= sum_d[ACC_W-1:0];
            ovf_q    <= ovf_acc_q | sum_d[ACC_W];
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= MUL;
          end
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: randomized scoreboard bench for mac_sequencer (ACC_W=7 and ACC_W=6 instances)
module tb_mac_sequencer;
  localparam int NP = 2;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [11:0] operands = '0;
  logic        busy7, done7, ovf7, busy6, done6, ovf6;
  logic [6:0]  res7;
  logic [5:0]  res6;
  int checks = 0, errors = 0;
  typedef struct {int de; int r7; int r6; logic o6;} exp_t;
  exp_t q[$];
  int edge_n = 0, free_at = 0, acc_edge = 0;
  logic active = 1'b0;
  int held7 = 0, held6 = 0;
  logic held_o6 = 1'b0;

  mac_sequencer #(.N_PAIRS(NP), .ACC_W(7), .IDX_W(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .operands(operands),
    .busy(busy7), .done(done7), .result(res7), .ovf(ovf7));
  mac_sequencer #(.N_PAIRS(NP), .ACC_W(6), .IDX_W(1)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start), .operands(operands),
    .busy(busy6), .done(done6), .result(res6), .ovf(ovf6));

  always #5 clk = ~clk;

  function automatic int sop(input logic [11:0] op);
    int s = 0;
    for (int i = 0; i < NP; i++) begin
      int x, y;
      x = int'(op[6*i+3 +: 3]);
      y = int'(op[6*i +: 3]);
      s += x * y;
    end
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // reference model: an operation is accepted whenever start is seen while the unit is free
  always @(posedge clk) begin
    edge_n++;
    if (rst_n && start && edge_n >= free_at) begin
      int s;
      s = sop(operands);
      q.push_back('{edge_n + 2*NP, s % 128, s % 64, s >= 64});
      acc_edge = edge_n;
      free_at  = edge_n + 2*NP + 2;
      active   = 1'b1;
    end
  end

  // monitor: pops the scoreboard on done and checks busy/held result every cycle
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].de < edge_n) begin
      chk("missing_done", 0, 1);
      void'(q.pop_front());
    end
    chk("done_pair", int'(done6), int'(done7));
    if (done7) begin
      if (q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("done_edge", edge_n, e.de);
        chk("result7", int'(res7), e.r7);
        chk("ovf7", int'(ovf7), 0);
        chk("result6", int'(res6), e.r6);
        chk("ovf6", int'(ovf6), int'(e.o6));
        held7 = e.r7; held6 = e.r6; held_o6 = e.o6;
      end
    end else begin
      chk("held7", int'(res7), held7);
      chk("held6", int'(res6), held6);
      chk("held_ovf6", int'(ovf6), int'(held_o6));
    end
    chk("busy", int'(busy7), int'(active && edge_n <= acc_edge + 2*NP));
    chk("busy6", int'(busy6), int'(busy7));
  end

  task automatic drive(input logic s, input logic [11:0] op);
    @(negedge clk);
    start = s;
    operands = op;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 12'($urandom));
  endtask

  task automatic do_reset;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy7), 0);
    chk("rst_result", int'(res7), 0);
    chk("rst_done", int'(done7), 0);
    chk("rst_ovf6", int'(ovf6), 0);
    q.delete();
    active = 1'b0; free_at = 0;
    held7 = 0; held6 = 0; held_o6 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3;
    chk("init_busy", int'(busy7), 0);
    chk("init_result", int'(res7), 0);
    chk("init_done", int'(done7), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 12'o3527);
    idle(7);
    drive(1'b1, 12'o7777);
    idle(7);
    drive(1'b1, 12'o3527);
    drive(1'b0, 12'o7777);
    drive(1'b1, 12'o1234);
    drive(1'b0, 12'o0000);
    drive(1'b1, 12'o5555);
    idle(4);
    drive(1'b1, 12'o2233);
    drive(1'b0, 12'o7777);
    idle(6);
    drive(1'b1, 12'o6666);
    idle(1);
    do_reset();
    idle(8);
    drive(1'b1, 12'o3527);
    idle(7);
    for (int i = 0; i < 20; i++) drive(1'b1, 12'o1111);
    idle(8);
    for (int i = 0; i < 400; i++) drive(($urandom % 3) == 0, 12'($urandom));
    idle(2);
    drive(1'b1, 12'o7654);
    idle(2);
    do_reset();
    drive(1'b1, 12'o7777);
    idle(10);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
